gate_checker: RTL and testbench

Self-checking response checker for 2-input combinational gate cells. It sweeps every input vector into the gate under test and samples the gate output after a programmable settle time. Each sample is compared against a parameterised truth table, and the block reports mismatch count, first failing vector and a pass flag. The same block is reused by every gate bench (and, or, xor, …) and by on-chip self-test wrappers, replacing hand-written per-gate stimulus sequences.

---
 rtl/gate_checker_if.sv | 30 +++
 rtl/gate_checker.sv | 148 ++++++++++++++
 tb/tb_gate_checker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_checker_if.sv
// Control, status and gate-drive signals for gate_checker.
// The slave modport is the checker; the master modport is whoever
// requests runs and owns the gate under test.
interface gate_checker_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_err_valid;
    logic [1:0]       first_err_vec;
    logic             dut_in1;
    logic             dut_in2;
    logic             dut_out;

    modport slave (
        input  start, abort, dut_out,
        output busy, done, pass, err_count, first_err_valid, first_err_vec,
        output dut_in1, dut_in2
    );

    modport master (
        output start, abort, dut_out,
        input  busy, done, pass, err_count, first_err_valid, first_err_vec,
        input  dut_in1, dut_in2
    );
endinterface

// File: rtl/gate_checker.sv
// Sweeps all four input vectors of a 2-input gate, samples its output after
// a settle time and compares against TRUTH_TABLE (bit index = {in1,in2}).
// Reports a saturating mismatch count, the first failing vector and pass.
module gate_checker #(
    parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    gate_checker_if.slave bus
);
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [LW-1:0]    loop_cnt, loop_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [1:0]       in_q, in_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             pass_q, pass_nxt;
    logic [ERR_W-1:0] err_q, err_nxt, err_upd;
    logic             fev_q, fev_nxt;
    logic [1:0]       fvec_q, fvec_nxt;
    logic             mismatch;

    assign mismatch = (bus.dut_out != TRUTH_TABLE[idx]);

    // Count including the current sample, saturating at all-ones.
    assign err_upd = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            loop_cnt   <= '0;
            settle_cnt <= '0;
            in_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fev_q      <= 1'b0;
            fvec_q     <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            loop_cnt   <= loop_nxt;
            settle_cnt <= settle_nxt;
            in_q       <= in_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            pass_q     <= pass_nxt;
            err_q      <= err_nxt;
            fev_q      <= fev_nxt;
            fvec_q     <= fvec_nxt;
        end
    end

    // Next-state and next-output logic; abort overrides any sample.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        loop_nxt   = loop_cnt;
        settle_nxt = settle_cnt;
        in_nxt     = in_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        pass_nxt   = pass_q;
        err_nxt    = err_q;
        fev_nxt    = fev_q;
        fvec_nxt   = fvec_q;

        if ((state == SETTLE || state == SAMPLE) && bus.abort) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            in_nxt    = '0;
            pass_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt  = SETTLE;
                        idx_nxt    = '0;
                        loop_nxt   = '0;
                        settle_nxt = SW'(SETTLE_CYCLES);
                        in_nxt     = '0;
                        busy_nxt   = 1'b1;
                        pass_nxt   = 1'b0;
                        err_nxt    = '0;
                        fev_nxt    = 1'b0;
                        fvec_nxt   = '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SW'(1)) begin
                        state_nxt = SAMPLE;
                    end else begin
                        settle_nxt = settle_cnt - SW'(1);
                    end
                end
                SAMPLE: begin
                    err_nxt = err_upd;
                    if (mismatch && !fev_q) begin
                        fev_nxt  = 1'b1;
                        fvec_nxt = idx;
                    end
                    if (idx == 2'd3 && loop_cnt == LW'(LOOPS - 1)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        in_nxt    = '0;
                        pass_nxt  = (err_upd == '0);
                    end else begin
                        state_nxt  = SETTLE;
                        idx_nxt    = idx + 2'd1;
                        in_nxt     = idx + 2'd1;
                        settle_nxt = SW'(SETTLE_CYCLES);
                        if (idx == 2'd3) begin
                            loop_nxt = loop_cnt + LW'(1);
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in1         = in_q[1];
    assign bus.dut_in2         = in_q[0];
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_vec   = fvec_q;
endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: default instance against AND / stuck-at-0 /
// OR gates with abort, reset and restart-while-busy cases; a second instance
// with ERR_W=2, LOOPS=2 against an inverted AND for saturation.
module tb_gate_checker;
    logic clk;
    logic rst_n;
    logic [1:0] mode_a;   // 0 AND, 1 stuck-at-0, 2 OR, 3 NAND
    int unsigned checks;
    int unsigned errors;

    gate_checker_if #(.ERR_W(8)) bus_a ();
    gate_checker_if #(.ERR_W(2)) bus_b ();

    gate_checker #(
        .TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    gate_checker #(
        .TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models driven by the checkers' vectors.
    always_comb begin
        case (mode_a)
            2'd0:    bus_a.dut_out = bus_a.dut_in1 & bus_a.dut_in2;
            2'd1:    bus_a.dut_out = 1'b0;
            2'd2:    bus_a.dut_out = bus_a.dut_in1 | bus_a.dut_in2;
            default: bus_a.dut_out = ~(bus_a.dut_in1 & bus_a.dut_in2);
        endcase
    end
    always_comb bus_b.dut_out = ~(bus_b.dut_in1 & bus_b.dut_in2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] vec_a();
        return {bus_a.dut_in1, bus_a.dut_in2};
    endfunction

    // One full default run on instance A; checks vector timing and done edge.
    task automatic run_a(input logic [1:0] mode, input bit restart);
        mode_a = mode;
        bus_a.start = 1'b1;
        tick();                       // E0
        bus_a.start = 1'b0;
        check("busy_after_e0", bus_a.busy, 1);
        check("vec_after_e0", vec_a(), 2'b00);
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (restart && e == 4) bus_a.start = 1'b1;
            if (e == 5) bus_a.start = 1'b0;
            if (e == 2)  check("vec00_held", vec_a(), 2'b00);
            if (e == 3)  check("vec01", vec_a(), 2'b01);
            if (e == 6)  check("vec10", vec_a(), 2'b10);
            if (e == 9)  check("vec11", vec_a(), 2'b11);
            if (e == 11) begin
                check("busy_last_sample", bus_a.busy, 1);
                check("no_early_done", bus_a.done, 0);
            end
            if (e == 12) begin
                check("done_e12", bus_a.done, 1);
                check("busy_in_done", bus_a.busy, 0);
            end
            if (e == 13) check("done_one_cycle", bus_a.done, 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode_a = 2'd0;
        rst_n = 1'b0;
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;
        tick();
        check("rst_busy", bus_a.busy, 0);
        check("rst_err", bus_a.err_count, 0);
        check("rst_pass", bus_a.pass, 0);
        check("rst_vec", vec_a(), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Ideal AND gate
        run_a(2'd0, 1'b0);
        check("and_pass", bus_a.pass, 1);
        check("and_err", bus_a.err_count, 0);
        check("and_fev", bus_a.first_err_valid, 0);

        // Stuck-at-0
        run_a(2'd1, 1'b0);
        check("sa0_err", bus_a.err_count, 1);
        check("sa0_fvec", bus_a.first_err_vec, 2'b11);
        check("sa0_fev", bus_a.first_err_valid, 1);
        check("sa0_pass", bus_a.pass, 0);

        // OR gate against AND table
        run_a(2'd2, 1'b0);
        check("or_err", bus_a.err_count, 2);
        check("or_fvec", bus_a.first_err_vec, 2'b01);
        check("or_pass", bus_a.pass, 0);

        // AND again so pass is high going into the abort run
        run_a(2'd0, 1'b0);
        check("and2_pass", bus_a.pass, 1);

        // Abort while vector 10 is driven (OR gate already failed on 01)
        mode_a = 2'd2;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        check("pre_abort_vec", vec_a(), 2'b10);
        bus_a.abort = 1'b1;
        tick();                       // E8 takes abort
        bus_a.abort = 1'b0;
        check("abort_busy", bus_a.busy, 0);
        check("abort_vec", vec_a(), 2'b00);
        check("abort_pass", bus_a.pass, 0);
        check("abort_err_kept", bus_a.err_count, 1);
        check("abort_fev_kept", bus_a.first_err_valid, 1);
        check("abort_fvec_kept", bus_a.first_err_vec, 2'b01);
        begin
            logic saw_done;
            saw_done = bus_a.done;
            for (int e = 0; e < 12; e++) begin
                tick();
                saw_done = saw_done | bus_a.done;
            end
            check("abort_no_done", saw_done, 0);
        end

        // Fresh start after abort completes cleanly
        run_a(2'd0, 1'b0);
        check("post_abort_pass", bus_a.pass, 1);
        check("post_abort_err", bus_a.err_count, 0);

        // Asynchronous reset mid-SETTLE
        mode_a = 2'd2;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        check("pre_rst_err", bus_a.err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus_a.busy, 0);
        check("mid_rst_vec", vec_a(), 2'b00);
        check("mid_rst_err", bus_a.err_count, 0);
        check("mid_rst_fev", bus_a.first_err_valid, 0);
        check("mid_rst_fvec", bus_a.first_err_vec, 0);
        check("mid_rst_done", bus_a.done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", bus_a.busy, 0);

        // Start pulsed while busy: ignored, done timing unchanged
        run_a(2'd0, 1'b1);
        check("restart_pass", bus_a.pass, 1);
        tick();
        check("restart_not_queued", bus_a.busy, 0);

        // Instance B: ERR_W=2, LOOPS=2, inverted AND
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (e == 6)  check("b_err_e6", bus_b.err_count, 2);
            if (e == 9)  check("b_err_e9", bus_b.err_count, 3);
            if (e == 12) check("b_err_sat", bus_b.err_count, 3);
            if (e == 12) check("b_busy_loop2", bus_b.busy, 1);
            if (e == 23) check("b_no_early_done", bus_b.done, 0);
            if (e == 24) begin
                check("b_done_e24", bus_b.done, 1);
                check("b_err_final", bus_b.err_count, 3);
                check("b_fvec", bus_b.first_err_vec, 2'b00);
                check("b_fev", bus_b.first_err_valid, 1);
                check("b_pass", bus_b.pass, 0);
            end
            if (e == 25) check("b_done_low", bus_b.done, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
